// File: rtl/pacman_motion.sv
// Pac-Man motion: button latch, frame-tick step divider and wall-query handshake.
// Optional PACMAN_TUNNEL_WRAP_EN wraps horizontal moves across the x bounds.
module pacman_motion #(
  parameter logic [9:0] START_X         = 10'd305,
  parameter logic [9:0] START_Y         = 10'd225,
  parameter logic [9:0] STEP            = 10'd1,
  parameter logic [3:0] FRAMES_PER_STEP = 4'd1,
  parameter logic [9:0] X_MIN           = 10'd144,
  parameter logic [9:0] X_MAX           = 10'd753,
  parameter logic [9:0] Y_MIN           = 10'd35,
  parameter logic [9:0] Y_MAX           = 10'd484
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       wall_req,
  output logic [9:0] wall_qx,
  output logic [9:0] wall_qy,
  input  logic       wall_ack,
  input  logic       wall_blocked,
  output logic [9:0] pm_xpos,
  output logic [9:0] pm_ypos,
  output logic [3:0] pm_direction,
  output logic       moving
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRY_WANT = 2'd1;
  localparam logic [1:0] TRY_CUR  = 2'd2;

  logic [1:0] state;
  logic [3:0] want_dir;
  logic [3:0] try_dir;
  logic [3:0] div;
  logic       step_due;
  logic       oob_pend;

  logic [3:0]  btns;
  logic        tick_hit;
  logic        resolve;
  logic        blk;
  logic [20:0] cw;
  logic [20:0] cc;

  // Returns {blocked_by_bounds, cand_x, cand_y}; 11-bit math exposes wrap.
  function automatic logic [20:0] cand_of(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [3:0] d
  );
    logic [10:0] cx;
    logic [10:0] cy;
    logic [9:0]  nx;
    logic        lo;
    logic        hi;
    logic        vbad;
    logic        bad;
    cx = {1'b0, x};
    cy = {1'b0, y};
    unique case (1'b1)
      d[0]:    cx = {1'b0, x} + {1'b0, STEP};
      d[1]:    cx = {1'b0, x} - {1'b0, STEP};
      d[2]:    cy = {1'b0, y} - {1'b0, STEP};
      d[3]:    cy = {1'b0, y} + {1'b0, STEP};
      default: ;
    endcase
    lo   = cx[10] ? d[1] : (cx[9:0] < X_MIN);
    hi   = cx[10] ? !d[1] : (cx[9:0] > X_MAX);
    vbad = cy[10] || (cy[9:0] < Y_MIN) ||
           (cy[9:0] > Y_MAX);
`ifdef PACMAN_TUNNEL_WRAP_EN
    if (hi)
      nx = X_MIN;
    else if (lo)
      nx = X_MAX;
    else
      nx = cx[9:0];
    bad = vbad;
`else
    nx  = cx[9:0];
    bad = hi || lo || vbad;
`endif
    return {bad, nx, cy[9:0]};
  endfunction

  assign btns     = {btn_down, btn_up, btn_left, btn_right};
  assign tick_hit = frame_tick &&
                    (div == FRAMES_PER_STEP - 4'd1);
  assign cw       = cand_of(pm_xpos, pm_ypos, want_dir);
  assign cc       = cand_of(pm_xpos, pm_ypos, pm_direction);
  assign resolve  = oob_pend || (wall_req && wall_ack);
  assign blk      = oob_pend || wall_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      want_dir     <= 4'd0;
      try_dir      <= 4'd0;
      div          <= 4'd0;
      step_due     <= 1'b0;
      oob_pend     <= 1'b0;
      wall_req     <= 1'b0;
      wall_qx      <= 10'd0;
      wall_qy      <= 10'd0;
      pm_xpos      <= START_X;
      pm_ypos      <= START_Y;
      pm_direction <= 4'b0001;
      moving       <= 1'b0;
    end else begin
      if (frame_tick)
        div <= tick_hit ? 4'd0 : div + 4'd1;
      step_due <= (step_due && state != IDLE) || tick_hit;
      if ($onehot(btns))
        want_dir <= btns;

      unique case (state)
        IDLE: begin
          if (step_due) begin
            if (want_dir != 4'd0 &&
                want_dir != pm_direction) begin
              state    <= TRY_WANT;
              try_dir  <= want_dir;
              wall_req <= !cw[20];
              oob_pend <= cw[20];
              if (!cw[20]) begin
                wall_qx <= cw[19:10];
                wall_qy <= cw[9:0];
              end
            end else begin
              state    <= TRY_CUR;
              wall_req <= !cc[20];
              oob_pend <= cc[20];
              if (!cc[20]) begin
                wall_qx <= cc[19:10];
                wall_qy <= cc[9:0];
              end
            end
          end
        end
        TRY_WANT: begin
          if (resolve) begin
            wall_req <= 1'b0;
            oob_pend <= 1'b0;
            if (!blk) begin
              pm_xpos      <= wall_qx;
              pm_ypos      <= wall_qy;
              pm_direction <= try_dir;
              want_dir     <= 4'd0;
              moving       <= 1'b1;
              state        <= IDLE;
            end else begin
              // Turn refused: retry straight ahead with a fresh query.
              state    <= TRY_CUR;
              wall_req <= !cc[20];
              oob_pend <= cc[20];
              if (!cc[20]) begin
                wall_qx <= cc[19:10];
                wall_qy <= cc[9:0];
              end
            end
          end
        end
        TRY_CUR: begin
          if (resolve) begin
            wall_req <= 1'b0;
            oob_pend <= 1'b0;
            moving   <= !blk;
            state    <= IDLE;
            if (!blk) begin
              pm_xpos <= wall_qx;
              pm_ypos <= wall_qy;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
